// File: rtl/csa_resolver.sv
// csa_resolver: carry-propagate back end for the Wallace-tree multiplier.
// Resolves the redundant (S, C) pair from the last CSA stage into S + 2*C,
// CHUNK bits per clock, with valid/ready handshakes on both sides.
// Optional feature: define CSA_RESOLVER_OVF_EN to add the 'ovf' output, which flags
// results that do not fit in WIDTH bits.
module csa_resolver #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s_in,
    input  logic [WIDTH-1:0] c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] sum_out
`ifdef CSA_RESOLVER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NCHUNK = (WIDTH + 2 + CHUNK - 1) / CHUNK;
    localparam int unsigned EXTW   = NCHUNK * CHUNK;
    localparam int unsigned CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNTW-1:0] LastCnt = CNTW'(NCHUNK - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    // Operands and result kept as chunk arrays so the active chunk is a plain index.
    logic [NCHUNK-1:0][CHUNK-1:0] a_q, b_q, sum_q;
    logic [NCHUNK-1:0][CHUNK-1:0] a_ext, b_ext;
    logic [EXTW-1:0]              sum_flat;
    logic                         carry_q;
    logic [CNTW-1:0]              cnt_q;
    logic [CHUNK:0]               chunk_add;

    // S sits at weight 2^i, C at 2^(i+1): shift C left by one before zero-extending.
    assign a_ext    = EXTW'(s_in);
    assign b_ext    = EXTW'({c_in, 1'b0});
    assign sum_flat = sum_q;

    // Ripple adder for the chunk currently being resolved.
    assign chunk_add = {1'b0, a_q[cnt_q]} + {1'b0, b_q[cnt_q]} + {{CHUNK{1'b0}}, carry_q};

    // Padding bits above WIDTH+2 are always zero and never leave the block.
    if (EXTW > WIDTH + 2) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^sum_flat[EXTW-1:WIDTH+2];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, one chunk per RUN cycle, hold in DONE until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = StRun;
            StRun:   if (cnt_q == LastCnt) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: capture on accept, then resolve chunk cnt_q each RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (state_q == StIdle && in_valid) begin
            a_q     <= a_ext;
            b_q     <= b_ext;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (state_q == StRun) begin
            sum_q[cnt_q] <= chunk_add[CHUNK-1:0];
            carry_q      <= chunk_add[CHUNK];
            cnt_q        <= cnt_q + CNTW'(1);
        end
    end

    // Outputs decoded from state; in_ready and out_valid are mutually exclusive by construction.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        sum_out   = sum_flat[WIDTH+1:0];
`ifdef CSA_RESOLVER_OVF_EN
        ovf       = out_valid & (|sum_flat[WIDTH+1:WIDTH]);
`endif
    end

endmodule
